stage_id_buffered: RTL and testbench

Decode-stage front end that replaces the single-register IF→ID handoff with a parametrised instruction queue. It sits between IF and EX. Each cycle it reads the register file for the queue head and resolves EX/MEM forwarding. It detects load-use hazards and inserts bubbles, tracks delay-slot status internally to produce the exception PC, and registers one issued instruction per cycle toward EX.

---
 rtl/id_pkg.sv | 124 ++++++++++++
 rtl/stage_id_buffered_queue.sv | 63 ++++++
 rtl/stage_id_buffered.sv | 150 +++++++++++++++
 tb/tb_stage_id_buffered.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Decode-stage package: MIPS opcode/funct encodings and the operand-use and
// branch-class decode helpers shared by the decode front end.
//   uses_rs(instr)   - instruction reads the rs field as a source register
//   uses_rt(instr)   - instruction reads the rt field as a source register
//   is_branch(instr) - J, JAL, JR, JALR, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ
package id_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned QENTRY_W = 64;  // {pc, instr}

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_REGIMM  = 6'h01,
    OP_J       = 6'h02,
    OP_JAL     = 6'h03,
    OP_BEQ     = 6'h04,
    OP_BNE     = 6'h05,
    OP_BLEZ    = 6'h06,
    OP_BGTZ    = 6'h07,
    OP_ADDI    = 6'h08,
    OP_ADDIU   = 6'h09,
    OP_SLTI    = 6'h0a,
    OP_SLTIU   = 6'h0b,
    OP_ANDI    = 6'h0c,
    OP_ORI     = 6'h0d,
    OP_XORI    = 6'h0e,
    OP_LUI     = 6'h0f,
    OP_LB      = 6'h20,
    OP_LH      = 6'h21,
    OP_LWL     = 6'h22,
    OP_LW      = 6'h23,
    OP_LBU     = 6'h24,
    OP_LHU     = 6'h25,
    OP_LWR     = 6'h26,
    OP_SB      = 6'h28,
    OP_SH      = 6'h29,
    OP_SWL     = 6'h2a,
    OP_SW      = 6'h2b,
    OP_SWR     = 6'h2e
  } opcode_e;

  typedef enum logic [5:0] {
    F_SLL   = 6'h00,
    F_SRL   = 6'h02,
    F_SRA   = 6'h03,
    F_SLLV  = 6'h04,
    F_SRLV  = 6'h06,
    F_SRAV  = 6'h07,
    F_JR    = 6'h08,
    F_JALR  = 6'h09,
    F_MFHI  = 6'h10,
    F_MTHI  = 6'h11,
    F_MFLO  = 6'h12,
    F_MTLO  = 6'h13,
    F_MULT  = 6'h18,
    F_MULTU = 6'h19,
    F_DIV   = 6'h1a,
    F_DIVU  = 6'h1b,
    F_ADD   = 6'h20,
    F_ADDU  = 6'h21,
    F_SUB   = 6'h22,
    F_SUBU  = 6'h23,
    F_AND   = 6'h24,
    F_OR    = 6'h25,
    F_XOR   = 6'h26,
    F_NOR   = 6'h27,
    F_SLT   = 6'h2a,
    F_SLTU  = 6'h2b
  } funct_e;

  // REGIMM rt-field selectors that count as branches
  localparam logic [4:0] RI_BLTZ = 5'h00;
  localparam logic [4:0] RI_BGEZ = 5'h01;

  function automatic logic uses_rs(input logic [INSTR_W-1:0] instr);
    logic r;
    r = 1'b0;
    case (opcode_e'(instr[31:26]))
      OP_SPECIAL: begin
        case (funct_e'(instr[5:0]))
          F_SLL, F_SRL, F_SRA, F_MFHI, F_MFLO: r = 1'b0;
          default:                             r = 1'b1;
        endcase
      end
      OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR:  r = 1'b1;
      default:                              r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic uses_rt(input logic [INSTR_W-1:0] instr);
    logic r;
    r = 1'b0;
    case (opcode_e'(instr[31:26]))
      OP_SPECIAL: begin
        case (funct_e'(instr[5:0]))
          F_JR, F_JALR, F_MFHI, F_MTHI, F_MFLO, F_MTLO: r = 1'b0;
          default:                                      r = 1'b1;
        endcase
      end
      // LWL/LWR merge into rt, so they read it too
      OP_BEQ, OP_BNE, OP_LWL, OP_LWR,
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: r = 1'b1;
      default:                             r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_branch(input logic [INSTR_W-1:0] instr);
    logic r;
    r = 1'b0;
    case (opcode_e'(instr[31:26]))
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: r = 1'b1;
      OP_REGIMM:  r = (instr[20:16] == RI_BLTZ) || (instr[20:16] == RI_BGEZ);
      OP_SPECIAL: r = (instr[5:0] == F_JR) || (instr[5:0] == F_JALR);
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stage_id_buffered_queue.sv
// id_fetch_queue: synchronous FIFO holding fetched {pc, instr} entries.
//   push/pop   - requests; ignored when full/empty respectively
//   flush      - synchronous clear of pointers and count; beats push/pop
//   wr_data    - entry to enqueue
//   rd_data    - current head entry (valid when !empty)
//   count      - occupancy, full/empty flags derived from it
module id_fetch_queue #(
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned WIDTH  = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wr_data,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(QDEPTH+1)-1:0]  count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = $clog2(QDEPTH+1);

  logic [WIDTH-1:0] mem [QDEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(QDEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; stale entries are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stage_id_buffered.sv
// Decode-stage front end with an instruction queue between IF and EX.
// Reads the register file for the queue head, forwards from EX/MEM, stalls
// on load-use hazards with bubbles, tracks delay slots to form the exception
// PC, and registers one issued instruction per cycle toward EX.
//   IF side : if_valid/if_pc/if_instr in, if_ready out (queue not full)
//   control : flush (discard everything), ex_stall (hold output register)
//   RF      : rf_addr1/2 out (head rs/rt), rf_data1/2 in (combinational)
//   fwd     : ex_wb_addr/data, ex_is_load, mem_wb_addr/data
//   EX side : id_valid, id_pc, id_instr, id_reg{1,2}_addr/data,
//             id_in_delay_slot, id_epc
//   status  : q_count
module stage_id_buffered
  import id_pkg::*;
#(
  parameter int unsigned QDEPTH    = 4,
  parameter int unsigned REGADDR_W = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         if_valid,
  input  logic [31:0]                  if_pc,
  input  logic [31:0]                  if_instr,
  output logic                         if_ready,
  input  logic                         flush,
  input  logic                         ex_stall,
  output logic [REGADDR_W-1:0]         rf_addr1,
  output logic [REGADDR_W-1:0]         rf_addr2,
  input  logic [31:0]                  rf_data1,
  input  logic [31:0]                  rf_data2,
  input  logic [REGADDR_W-1:0]         ex_wb_addr,
  input  logic [31:0]                  ex_wb_data,
  input  logic                         ex_is_load,
  input  logic [REGADDR_W-1:0]         mem_wb_addr,
  input  logic [31:0]                  mem_wb_data,
  output logic                         id_valid,
  output logic [31:0]                  id_pc,
  output logic [31:0]                  id_instr,
  output logic [REGADDR_W-1:0]         id_reg1_addr,
  output logic [REGADDR_W-1:0]         id_reg2_addr,
  output logic [31:0]                  id_reg1_data,
  output logic [31:0]                  id_reg2_data,
  output logic                         id_in_delay_slot,
  output logic [31:0]                  id_epc,
  output logic [$clog2(QDEPTH+1)-1:0]  q_count
);

  logic [QENTRY_W-1:0] head;
  logic [31:0]         head_pc;
  logic [31:0]         head_instr;
  logic                q_full;
  logic                q_empty;
  logic                push;
  logic                pop;
  logic                hazard;
  logic                issue;
  logic [REGADDR_W-1:0] rs;
  logic [REGADDR_W-1:0] rt;
  logic [31:0]         op1;
  logic [31:0]         op2;
  logic                ds_flag;

  assign if_ready = !q_full;
  assign push     = if_valid && if_ready;

  id_fetch_queue #(
    .QDEPTH (QDEPTH),
    .WIDTH  (QENTRY_W)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data ({if_pc, if_instr}),
    .rd_data (head),
    .count   (q_count),
    .full    (q_full),
    .empty   (q_empty)
  );

  assign head_pc    = head[63:32];
  assign head_instr = head[31:0];
  assign rs         = REGADDR_W'(head_instr[25:21]);
  assign rt         = REGADDR_W'(head_instr[20:16]);
  assign rf_addr1   = rs;
  assign rf_addr2   = rt;

  function automatic logic [31:0] fwd_sel(
    input logic [REGADDR_W-1:0] a,
    input logic [REGADDR_W-1:0] ex_a,
    input logic [31:0]          ex_d,
    input logic [REGADDR_W-1:0] mem_a,
    input logic [31:0]          mem_d,
    input logic [31:0]          rf_d
  );
    logic [31:0] r;
    if (a == '0)         r = '0;
    else if (a == ex_a)  r = ex_d;
    else if (a == mem_a) r = mem_d;
    else                 r = rf_d;
    return r;
  endfunction

  always_comb begin
    op1    = fwd_sel(rs, ex_wb_addr, ex_wb_data, mem_wb_addr, mem_wb_data, rf_data1);
    op2    = fwd_sel(rt, ex_wb_addr, ex_wb_data, mem_wb_addr, mem_wb_data, rf_data2);
    hazard = !q_empty && ex_is_load && (ex_wb_addr != '0) &&
             ((uses_rs(head_instr) && (rs == ex_wb_addr)) ||
              (uses_rt(head_instr) && (rt == ex_wb_addr)));
    issue  = !ex_stall && !q_empty && !hazard;
  end

  // The queue ignores pop during flush, so no extra gating is needed here
  assign pop = issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid         <= 1'b0;
      id_pc            <= '0;
      id_instr         <= '0;
      id_reg1_addr     <= '0;
      id_reg2_addr     <= '0;
      id_reg1_data     <= '0;
      id_reg2_data     <= '0;
      id_in_delay_slot <= 1'b0;
      id_epc           <= '0;
      ds_flag          <= 1'b0;
    end else if (flush) begin
      id_valid <= 1'b0;
      ds_flag  <= 1'b0;
    end else if (!ex_stall) begin
      if (issue) begin
        id_valid         <= 1'b1;
        id_pc            <= head_pc;
        id_instr         <= head_instr;
        id_reg1_addr     <= rs;
        id_reg2_addr     <= rt;
        id_reg1_data     <= op1;
        id_reg2_data     <= op2;
        // Delay-slot status is that of the previous issued instruction
        id_in_delay_slot <= ds_flag;
        id_epc           <= ds_flag ? (head_pc - 32'd4) : head_pc;
        ds_flag          <= is_branch(head_instr);
      end else begin
        id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stage_id_buffered.sv
module tb_stage_id_buffered;

  localparam int QDEPTH = 4;
  localparam int AW     = 5;
  localparam int CW     = $clog2(QDEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          if_valid;
  logic [31:0]   if_pc;
  logic [31:0]   if_instr;
  logic          if_ready;
  logic          flush;
  logic          ex_stall;
  logic [AW-1:0] rf_addr1, rf_addr2;
  logic [31:0]   rf_data1, rf_data2;
  logic [AW-1:0] ex_wb_addr;
  logic [31:0]   ex_wb_data;
  logic          ex_is_load;
  logic [AW-1:0] mem_wb_addr;
  logic [31:0]   mem_wb_data;
  logic          id_valid;
  logic [31:0]   id_pc, id_instr;
  logic [AW-1:0] id_reg1_addr, id_reg2_addr;
  logic [31:0]   id_reg1_data, id_reg2_data;
  logic          id_in_delay_slot;
  logic [31:0]   id_epc;
  logic [CW-1:0] q_count;

  logic [31:0] regs [32];
  assign rf_data1 = regs[rf_addr1];
  assign rf_data2 = regs[rf_addr2];

  always #5 clk = ~clk;

  stage_id_buffered #(.QDEPTH(QDEPTH), .REGADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_ready(if_ready), .flush(flush), .ex_stall(ex_stall),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .ex_wb_addr(ex_wb_addr), .ex_wb_data(ex_wb_data), .ex_is_load(ex_is_load),
    .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .id_reg1_addr(id_reg1_addr), .id_reg2_addr(id_reg2_addr),
    .id_reg1_data(id_reg1_data), .id_reg2_data(id_reg2_data),
    .id_in_delay_slot(id_in_delay_slot), .id_epc(id_epc), .q_count(q_count)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a plain queue of {pc, instr} and the expected output register
  logic [63:0] mq[$];
  logic        m_valid, m_ds, m_flag;
  logic [31:0] m_pc, m_instr, m_d1, m_d2, m_epc;
  logic [4:0]  m_a1, m_a2;

  // Instruction builders for the handful of instructions the bench uses
  function automatic logic [31:0] addiu(input logic [4:0] rt, rs, input logic [15:0] imm);
    return {6'h09, rs, rt, imm};
  endfunction
  function automatic logic [31:0] addu(input logic [4:0] rd, rs, rt);
    return {6'h00, rs, rt, rd, 5'd0, 6'h21};
  endfunction
  function automatic logic [31:0] beq(input logic [4:0] rs, rt, input logic [15:0] off);
    return {6'h04, rs, rt, off};
  endfunction
  function automatic logic [31:0] lui(input logic [4:0] rt, input logic [15:0] imm);
    return {6'h0f, 5'd0, rt, imm};
  endfunction
  function automatic logic [31:0] jmp(input logic [25:0] t);
    return {6'h02, t};
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rt, rs, input logic [15:0] off);
    return {6'h23, rs, rt, off};
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] rt, rs, input logic [15:0] off);
    return {6'h2b, rs, rt, off};
  endfunction
  function automatic logic [31:0] sll(input logic [4:0] rd, rt, sa);
    return {6'h00, 5'd0, rt, rd, sa, 6'h00};
  endfunction

  // Source usage of the generated mnemonics: ADDIU rs; ADDU rs,rt; BEQ rs,rt;
  // LW rs; SW rs,rt; SLL rt; LUI and J none. Branches: BEQ, J.
  function automatic logic m_reads_rs(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    if (op == 6'h00) return ins[5:0] == 6'h21;
    return (op == 6'h09) || (op == 6'h04) || (op == 6'h23) || (op == 6'h2b);
  endfunction
  function automatic logic m_reads_rt(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    return (op == 6'h00) || (op == 6'h04) || (op == 6'h2b);
  endfunction
  function automatic logic m_branch(input logic [31:0] ins);
    return (ins[31:26] == 6'h04) || (ins[31:26] == 6'h02);
  endfunction

  function automatic logic [31:0] m_operand(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (a == ex_wb_addr) return ex_wb_data;
    if (a == mem_wb_addr) return mem_wb_data;
    return regs[a];
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    c = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 7))
      0: return addiu(a, b, 16'($urandom));
      1: return addu(a, b, c);
      2: return beq(a, b, 16'($urandom));
      3: return lui(a, 16'($urandom));
      4: return jmp(26'($urandom));
      5: return lw(a, b, 16'($urandom));
      6: return sw(a, b, 16'($urandom));
      default: return sll(a, b, c);
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0;
    m_flag  = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs currently driven
  task automatic model_edge();
    int          sz0;
    logic [63:0] h;
    logic [4:0]  rs, rt;
    logic        haz;
    sz0 = mq.size();
    if (flush) begin
      mq.delete();
      m_valid = 1'b0;
      m_flag  = 1'b0;
    end else begin
      if (!ex_stall) begin
        haz = 1'b0;
        if (sz0 > 0) begin
          rs  = mq[0][25:21];
          rt  = mq[0][20:16];
          haz = ex_is_load && (ex_wb_addr != 0) &&
                ((m_reads_rs(mq[0][31:0]) && rs == ex_wb_addr) ||
                 (m_reads_rt(mq[0][31:0]) && rt == ex_wb_addr));
        end
        if (sz0 > 0 && !haz) begin
          h       = mq.pop_front();
          m_valid = 1'b1;
          m_pc    = h[63:32];
          m_instr = h[31:0];
          m_a1    = m_instr[25:21];
          m_a2    = m_instr[20:16];
          m_d1    = m_operand(m_a1);
          m_d2    = m_operand(m_a2);
          m_ds    = m_flag;
          m_epc   = m_flag ? m_pc - 32'd4 : m_pc;
          m_flag  = m_branch(m_instr);
        end else begin
          m_valid = 1'b0;
        end
      end
      if (if_valid && sz0 < QDEPTH) mq.push_back({if_pc, if_instr});
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("id_valid", 32'(id_valid), 32'(m_valid));
    chk("q_count", 32'(q_count), mq.size());
    chk("if_ready", 32'(if_ready), 32'(mq.size() != QDEPTH));
    if (m_valid) begin
      chk("id_pc", id_pc, m_pc);
      chk("id_instr", id_instr, m_instr);
      chk("id_reg1_addr", 32'(id_reg1_addr), 32'(m_a1));
      chk("id_reg2_addr", 32'(id_reg2_addr), 32'(m_a2));
      chk("id_reg1_data", id_reg1_data, m_d1);
      chk("id_reg2_data", id_reg2_data, m_d2);
      chk("id_in_delay_slot", 32'(id_in_delay_slot), 32'(m_ds));
      chk("id_epc", id_epc, m_epc);
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins);
    if_valid = 1'b1;
    if_pc    = pc;
    if_instr = ins;
    cycle();
  endtask

  task automatic idle(input int n);
    if_valid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_id_valid"}, 32'(id_valid), 32'd0);
    chk({tag, "_q_count"}, 32'(q_count), 32'd0);
    chk({tag, "_if_ready"}, 32'(if_ready), 32'd1);
    chk({tag, "_id_pc"}, id_pc, 32'd0);
    chk({tag, "_id_instr"}, id_instr, 32'd0);
    chk({tag, "_id_reg1_data"}, id_reg1_data, 32'd0);
    chk({tag, "_id_in_delay_slot"}, 32'(id_in_delay_slot), 32'd0);
    chk({tag, "_id_epc"}, id_epc, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_instr = '0; flush = 1'b0;
    ex_stall = 1'b0; ex_wb_addr = '0; ex_wb_data = '0; ex_is_load = 1'b0;
    mem_wb_addr = '0; mem_wb_data = '0;
    model_reset();
    #3;
    check_cleared("reset");
    #9 rst = 1'b0;

    // Streaming: 4 back-to-back ADDIUs
    for (int i = 0; i < 4; i++) begin
      push(32'h100 + 32'(4 * i), addiu(5'd8, 5'd9, 16'(i)));
      chk("stream_qcount_le1", 32'(q_count <= 1), 32'd1);
    end
    idle(3);

    // Load-use hazard then forwarding from EX
    ex_is_load = 1'b1; ex_wb_addr = 5'd1;
    push(32'h300, addu(5'd3, 5'd1, 5'd2));
    idle(1);
    chk("loaduse_bubble", 32'(id_valid), 32'd0);
    chk("loaduse_held", 32'(q_count), 32'd1);
    ex_is_load = 1'b0; ex_wb_addr = 5'd0;
    idle(1);
    chk("loaduse_rf1", id_reg1_data, regs[1]);
    chk("loaduse_rf2", id_reg2_data, regs[2]);
    ex_wb_addr = 5'd1; ex_wb_data = 32'h55;
    push(32'h304, addu(5'd3, 5'd1, 5'd2));
    idle(1);
    chk("ex_fwd", id_reg1_data, 32'h55);

    // Forwarding priority and the zero register
    ex_wb_addr = 5'd4; mem_wb_addr = 5'd4; ex_wb_data = 32'hA; mem_wb_data = 32'hB;
    push(32'h310, addu(5'd5, 5'd4, 5'd6));
    push(32'h314, addu(5'd5, 5'd0, 5'd4));
    chk("fwd_ex_over_mem", id_reg1_data, 32'hA);
    idle(1);
    chk("fwd_r0", id_reg1_data, 32'h0);
    chk("fwd_rt", id_reg2_data, 32'hA);
    ex_wb_addr = '0; mem_wb_addr = '0;
    idle(1);

    // Delay slot
    push(32'h200, beq(5'd1, 5'd2, 16'h0010));
    push(32'h204, addiu(5'd3, 5'd3, 16'h1));
    push(32'h208, addiu(5'd4, 5'd4, 16'h1));
    chk("ds_flag", 32'(id_in_delay_slot), 32'd1);
    chk("ds_epc", id_epc, 32'h200);
    idle(1);
    chk("ds_clear", 32'(id_in_delay_slot), 32'd0);
    chk("ds_epc_own", id_epc, 32'h208);
    idle(1);

    // Full queue under ex_stall
    ex_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h400 + 32'(4 * i), addiu(5'd1, 5'd2, 16'(i)));
    chk("full_count", 32'(q_count), 32'd4);
    chk("full_ready", 32'(if_ready), 32'd0);
    push(32'h410, addiu(5'd1, 5'd2, 16'h9));
    chk("full_refuse", 32'(q_count), 32'd4);
    ex_stall = 1'b0;
    idle(1);
    chk("drain_first", id_pc, 32'h400);
    idle(5);

    // Flush with a simultaneous push
    push(32'h600, addiu(5'd1, 5'd1, 16'h1));
    push(32'h604, addiu(5'd1, 5'd1, 16'h2));
    ex_stall = 1'b1;
    push(32'h608, addiu(5'd1, 5'd1, 16'h3));
    push(32'h60C, addiu(5'd1, 5'd1, 16'h4));
    chk("preflush_count", 32'(q_count), 32'd3);
    chk("preflush_valid", 32'(id_valid), 32'd1);
    flush = 1'b1;
    push(32'h610, addiu(5'd1, 5'd1, 16'h5));
    chk("flush_count", 32'(q_count), 32'd0);
    chk("flush_valid", 32'(id_valid), 32'd0);
    flush = 1'b0; ex_stall = 1'b0;
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if_valid    = ($urandom_range(0, 3) != 0);
      if_pc       = 32'h1000 + 32'(4 * i);
      if_instr    = rand_instr();
      ex_stall    = ($urandom_range(0, 4) == 0);
      flush       = ($urandom_range(0, 31) == 0);
      ex_is_load  = ($urandom_range(0, 2) == 0);
      ex_wb_addr  = 5'($urandom_range(0, 7));
      mem_wb_addr = 5'($urandom_range(0, 7));
      ex_wb_data  = $urandom;
      mem_wb_data = $urandom;
      cycle();
    end
    flush = 1'b0; ex_stall = 1'b0; ex_is_load = 1'b0;
    ex_wb_addr = '0; mem_wb_addr = '0;

    // Asynchronous reset mid-stream
    push(32'h700, addiu(5'd1, 5'd2, 16'h1));
    push(32'h704, beq(5'd1, 5'd2, 16'h1));
    push(32'h708, addiu(5'd1, 5'd2, 16'h2));
    #3 rst = 1'b1;
    model_reset();
    #1;
    check_cleared("async_rst");
    #2 rst = 1'b0;
    push(32'h500, addiu(5'd6, 5'd7, 16'h3));
    idle(1);
    chk("post_rst_head", id_pc, 32'h500);
    chk("post_rst_ds", 32'(id_in_delay_slot), 32'd0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
